hll_bucket_update: RTL

//  Downstream neighbour of leftmost_bit in the HLL kernel; owns the HLL register file.

---
 rtl/hll_bucket_update.sv | 256 +++++++++++++++++++++++++
 1 files changed

// File: rtl/hll_bucket_update.sv
// HLL register file: pairs ranks with their delayed bucket indices and applies max-update.
// Also clears the buckets and streams them out to the estimator over a valid/ready port.
module hll_bucket_update #(
    parameter int P         = 10,
    parameter int RANK_W    = 4,
    parameter int IDX_DELAY = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [P-1:0]      idx_in,
    input  logic              idx_valid,
    input  logic [RANK_W-1:0] rank_in,
    input  logic              rank_valid,
    input  logic              clear_start,
    input  logic              read_start,
    output logic              run,
    output logic              busy,
    output logic [P-1:0]      out_addr,
    output logic [RANK_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic [15:0]       drop_cnt
);
    localparam logic [P-1:0] LAST_ADDR = {P{1'b1}};

    typedef enum logic [1:0] {CLEAR = 2'd0, RUN = 2'd1, DRAIN = 2'd2, READ = 2'd3} state_t;

    function automatic logic [RANK_W-1:0] rank_max(input logic [RANK_W-1:0] a,
                                                   input logic [RANK_W-1:0] b);
        rank_max = (a > b) ? a : b;
    endfunction

    state_t              state_q, state_d, target_q, target_d;
    logic [P:0]          cnt_q, cnt_d;
    logic [P-1:0]        sr_q [IDX_DELAY];
    logic [P-1:0]        sr_d [IDX_DELAY];
    logic                u1_valid_q, u1_valid_d, u2_valid_q, u2_valid_d;
    logic [P-1:0]        u1_addr_q, u1_addr_d, u2_addr_q, u2_addr_d;
    logic [RANK_W-1:0]   u1_rank_q, u1_rank_d, u2_rank_q, u2_rank_d;
    logic [RANK_W-1:0]   u2_stored_q, u2_stored_d;
    logic                wb_valid_q, wb_valid_d;
    logic [P-1:0]        wb_addr_q, wb_addr_d;
    logic [RANK_W-1:0]   wb_data_q, wb_data_d;
    logic                pend_valid_q, pend_valid_d;
    logic [P-1:0]        pend_addr_q, pend_addr_d;
    logic                out_valid_q, out_valid_d, out_last_q, out_last_d;
    logic [P-1:0]        out_addr_q, out_addr_d;
    logic [RANK_W-1:0]   out_data_q, out_data_d;
    logic [15:0]         drop_q, drop_d;
    logic                run_q, run_d, busy_q, busy_d;

    logic [RANK_W-1:0]   mem_q [2**P];
    logic [RANK_W-1:0]   rd_data_q;
    logic                ram_re, ram_we, upd_fire, upd_we, out_free, issue;
    logic [P-1:0]        ram_ra, ram_wa;
    logic [RANK_W-1:0]   ram_wd;

    // Next-state: index line, update pipeline, FSM, stream-out and RAM port muxing.
    always_comb begin
        state_d      = state_q;
        target_d     = target_q;
        cnt_d        = cnt_q;
        pend_valid_d = pend_valid_q;
        pend_addr_d  = pend_addr_q;
        out_valid_d  = out_valid_q;
        out_addr_d   = out_addr_q;
        out_data_d   = out_data_q;
        out_last_d   = out_last_q;
        drop_d       = drop_q;
        issue        = 1'b0;
        out_free     = !out_valid_q || out_ready;

        // Invalid slots carry index 0 so the tap never holds stale indices.
        sr_d[0] = idx_valid ? idx_in : {P{1'b0}};
        for (int i = 1; i < IDX_DELAY; i++) begin
            sr_d[i] = sr_q[i-1];
        end

        upd_fire   = rank_valid && (state_q == RUN);
        u1_valid_d = upd_fire;
        u1_addr_d  = sr_q[IDX_DELAY-1];
        u1_rank_d  = rank_in;

        // Resolve the stored value: op in U2 is newest, then the write that raced our read.
        if (u2_valid_q && (u2_addr_q == u1_addr_q)) begin
            u2_stored_d = rank_max(u2_rank_q, u2_stored_q);
        end else if (wb_valid_q && (wb_addr_q == u1_addr_q)) begin
            u2_stored_d = wb_data_q;
        end else begin
            u2_stored_d = rd_data_q;
        end
        u2_valid_d = u1_valid_q;
        u2_addr_d  = u1_addr_q;
        u2_rank_d  = u1_rank_q;

        upd_we     = u2_valid_q && (u2_rank_q > u2_stored_q);
        wb_valid_d = upd_we;
        wb_addr_d  = u2_addr_q;
        wb_data_d  = u2_rank_q;

        ram_re = upd_fire;
        ram_ra = sr_q[IDX_DELAY-1];
        ram_we = upd_we;
        ram_wa = u2_addr_q;
        ram_wd = u2_rank_q;

        if (rank_valid && (state_q != RUN) && (drop_q != 16'hFFFF)) begin
            drop_d = drop_q + 16'd1;
        end else begin
            drop_d = drop_q;
        end

        case (state_q)
            CLEAR: begin
                ram_we = 1'b1;
                ram_wa = cnt_q[P-1:0];
                ram_wd = {RANK_W{1'b0}};
                if (cnt_q[P-1:0] == LAST_ADDR) begin
                    state_d = RUN;
                    cnt_d   = {(P+1){1'b0}};
                end else begin
                    cnt_d = cnt_q + (P+1)'(1);
                end
            end
            RUN: begin
                if (clear_start) begin
                    state_d  = DRAIN;
                    target_d = CLEAR;
                end else if (read_start) begin
                    state_d  = DRAIN;
                    target_d = READ;
                end else begin
                    state_d = RUN;
                end
            end
            DRAIN: begin
                if (!u1_valid_q && !u2_valid_q) begin
                    state_d = target_q;
                    cnt_d   = {(P+1){1'b0}};
                end else begin
                    state_d = DRAIN;
                end
            end
            READ: begin
                // The RAM read register holds while no read is issued, so a stalled pending word survives.
                issue = !cnt_q[P] && (!pend_valid_q || out_free);
                if (issue) begin
                    ram_re      = 1'b1;
                    ram_ra      = cnt_q[P-1:0];
                    cnt_d       = cnt_q + (P+1)'(1);
                    pend_addr_d = cnt_q[P-1:0];
                end else begin
                    pend_addr_d = pend_addr_q;
                end
                pend_valid_d = issue || (pend_valid_q && !out_free);
                if (pend_valid_q && out_free) begin
                    out_valid_d = 1'b1;
                    out_addr_d  = pend_addr_q;
                    out_data_d  = rd_data_q;
                    out_last_d  = (pend_addr_q == LAST_ADDR);
                end else if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                end else begin
                    out_valid_d = out_valid_q;
                end
                if (out_valid_q && out_ready && out_last_q) begin
                    state_d = RUN;
                end else begin
                    state_d = READ;
                end
            end
            default: begin
                state_d = CLEAR;
                cnt_d   = {(P+1){1'b0}};
            end
        endcase

        run_d  = (state_d == RUN);
        busy_d = !run_d;
    end

    // Control, pipeline and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= CLEAR;
            target_q     <= CLEAR;
            cnt_q        <= {(P+1){1'b0}};
            for (int i = 0; i < IDX_DELAY; i++) begin
                sr_q[i] <= {P{1'b0}};
            end
            u1_valid_q   <= 1'b0;
            u1_addr_q    <= {P{1'b0}};
            u1_rank_q    <= {RANK_W{1'b0}};
            u2_valid_q   <= 1'b0;
            u2_addr_q    <= {P{1'b0}};
            u2_rank_q    <= {RANK_W{1'b0}};
            u2_stored_q  <= {RANK_W{1'b0}};
            wb_valid_q   <= 1'b0;
            wb_addr_q    <= {P{1'b0}};
            wb_data_q    <= {RANK_W{1'b0}};
            pend_valid_q <= 1'b0;
            pend_addr_q  <= {P{1'b0}};
            out_valid_q  <= 1'b0;
            out_addr_q   <= {P{1'b0}};
            out_data_q   <= {RANK_W{1'b0}};
            out_last_q   <= 1'b0;
            drop_q       <= 16'd0;
            run_q        <= 1'b0;
            busy_q       <= 1'b1;
        end else begin
            state_q      <= state_d;
            target_q     <= target_d;
            cnt_q        <= cnt_d;
            sr_q         <= sr_d;
            u1_valid_q   <= u1_valid_d;
            u1_addr_q    <= u1_addr_d;
            u1_rank_q    <= u1_rank_d;
            u2_valid_q   <= u2_valid_d;
            u2_addr_q    <= u2_addr_d;
            u2_rank_q    <= u2_rank_d;
            u2_stored_q  <= u2_stored_d;
            wb_valid_q   <= wb_valid_d;
            wb_addr_q    <= wb_addr_d;
            wb_data_q    <= wb_data_d;
            pend_valid_q <= pend_valid_d;
            pend_addr_q  <= pend_addr_d;
            out_valid_q  <= out_valid_d;
            out_addr_q   <= out_addr_d;
            out_data_q   <= out_data_d;
            out_last_q   <= out_last_d;
            drop_q       <= drop_d;
            run_q        <= run_d;
            busy_q       <= busy_d;
        end
    end

    // Bucket RAM: one write and one synchronous read port, read-first, contents not reset.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem_q[ram_wa] <= ram_wd;
        end
        if (ram_re) begin
            rd_data_q <= mem_q[ram_ra];
        end
    end

    assign run       = run_q;
    assign busy      = busy_q;
    assign out_addr  = out_addr_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign drop_cnt  = drop_q;
endmodule
